iir_mc: RTL
===========

# iir_mc

Multi-channel, time-multiplexed 4-tap-feedforward / 2-tap-feedback IIR filter with run-time sign and shift configuration, per-channel state, valid handshake and selectable saturation. One shared datapath serves `N_CH` channels; each accepted sample carries its channel index, and that channel's private history registers are used and updated. Sits in the sample path between the input sample source and downstream decimation/logging. Replaces the single-channel fixed-coefficient filter.

## Interface
- `NB_DATA`, 8, sample width; two's complement signed.
- `N_CH`, 4, number of channels; ≥1.
- `NB_CH`, `$clog2(N_CH)` (min 1), channel index width.
- `NB_SH`, 3, feedback shift-amount width.
- `SAT`, 1, 1 = saturate result to `NB_DATA`; 0 = wrap (keep low `NB_DATA` bits).
- `i_clk` in 1: single clock, rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_valid` in 1: sample present this cycle.
- `i_ch` in `NB_CH`: channel of the sample.
- `i_data` in `NB_DATA`: signed sample x[n].
- `i_clr` in 1: clear history of channel `i_ch` (independent of `i_valid`).
- `i_b_neg` in 4: bit k = 1 subtracts tap x[n-k], else adds.
- `i_a1_sh`, `i_a2_sh` in `NB_SH` each: arithmetic right-shift for y[n-1], y[n-2].
- `i_fb_en` in 2: bit0 enables y[n-1] term, bit1 enables y[n-2] term.
- `o_valid` out 1: result valid.
- `o_ch` out `NB_CH`: channel of result.
- `o_data` out `NB_DATA`: signed y[n].

## Operation
- Per channel c: history regs x1,x2,x3,y1,y2 (`NB_DATA` each). x[n] = `i_data` (not stored before use).
- y[n] = Σk ±x[n-k] (k=0..3, sign per `i_b_neg[k]`) + fb_en[0]·(y1 >>> a1_sh) + fb_en[1]·(y2 >>> a2_sh).
- Accumulator `NB_DATA+3` bits, all operands sign-extended; no overflow inside accumulator.
- Result: `SAT`=1 clamp to [-2^(NB_DATA-1), 2^(NB_DATA-1)-1]; `SAT`=0 truncate to low `NB_DATA` bits.
- Stored y1 is the post-saturation/wrap result (what appears on `o_data`).
- Config inputs sampled only on the accepting cycle; may change every cycle.
- Accept: `i_valid`=1 and `i_ch` < `N_CH` and `i_rst`=0. On accept for channel c: x3←x2, x2←x1, x1←`i_data`, y2←y1, y1←result. Other channels untouched.
- `i_ch` ≥ `N_CH`: sample dropped, no state change, no `o_valid`; `i_clr` with `i_ch` ≥ `N_CH` ignored.
- `i_clr`=1 without `i_valid`: channel's five history regs → 0 at next edge.
- `i_clr`=1 with accepted `i_valid`: result computed with all-zero history; afterwards x1=`i_data`, y1=result, rest 0.
- No backpressure: block accepts every cycle.

## Timing
- Latency 1: sample accepted at edge t → `o_valid`=1, `o_ch`, `o_data` registered, visible after edge t (for cycle t+1).
- `o_valid` deasserts the cycle after a non-accepted cycle; `o_data`/`o_ch` hold last value when `o_valid`=0.
- Back-to-back samples on same channel at full rate: second sample sees history updated by first (history written at same edge as output).
- Reset: all history of all channels = 0, `o_valid`=0, `o_data`=0, `o_ch`=0 after the reset edge; inputs ignored while `i_rst`=1; reset mid-stream discards in-flight result.
- Throughput 1 sample/cycle aggregate across channels.

## Test plan
- Legacy impulse, `SAT`=0, `i_b_neg`=4'b0010, a1_sh=1, a2_sh=2, fb_en=2'b11, ch0: x = 8,0,0,0 consecutive → `o_data` = 8, -4, 8, 11, each 1 cycle after input, `o_ch`=0.
- Saturation, `SAT`=1, `i_b_neg`=0, a1_sh=1, fb_en=2'b01, x=127,127 → 127, 127 (raw 317 clamped); same with `SAT`=0 → 127, 61.
- Channel isolation: alternate ch0 x=8,0,0,0 with ch1 x=0 each cycle → ch1 outputs all 0, ch0 outputs 8,-4,8,11 in its slots; `i_ch`=N_CH mid-stream → no `o_valid`, no state change.
- Clear: after ch0 history nonzero, `i_clr`+`i_valid` with x=5, all b positive → `o_data`=5; next x=0 → 5 + (5>>>a1_sh) per config.
- Reset mid-stream: assert `i_rst` one cycle during ch0 run with `i_valid`=1 → `o_valid`=0, `o_data`=0 next cycle; repeat legacy impulse → 8,-4,8,11 again.
- Negative feedback rounding: y1=-3, a1_sh=1, fb only, x=0 → -2 (arithmetic shift toward -∞).

Source files
------------

// File: rtl/iir_mc.sv
// iir_mc: time-multiplexed multi-channel IIR filter.
//   y[n] = sum_k (+/-) x[n-k] (k = 0..3) + fb_en[0]*(y1 >>> a1_sh) + fb_en[1]*(y2 >>> a2_sh)
// One shared datapath; each accepted sample selects its channel's private history
// (x1, x2, x3, y1, y2), which is read and updated in the same cycle. Latency is one cycle.
//
// Ports:
//   i_clk              clock, rising edge
//   i_rst              synchronous active-high reset
//   i_valid            sample present this cycle
//   i_ch               channel index of the sample
//   i_data             signed sample x[n]
//   i_clr              clear history of channel i_ch (with or without i_valid)
//   i_b_neg            bit k set: subtract x[n-k] instead of adding
//   i_a1_sh, i_a2_sh   arithmetic right shift applied to y[n-1], y[n-2]
//   i_fb_en            bit0 enables the y[n-1] term, bit1 the y[n-2] term
//   o_valid            result valid
//   o_ch               channel of the result
//   o_data             signed result y[n]; o_data/o_ch hold while o_valid is low
module iir_mc #(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned N_CH    = 4,
    parameter int unsigned NB_CH   = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter int unsigned NB_SH   = 3,
    parameter bit          SAT     = 1'b1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic [NB_CH-1:0]   i_ch,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_clr,
    input  logic [3:0]         i_b_neg,
    input  logic [NB_SH-1:0]   i_a1_sh,
    input  logic [NB_SH-1:0]   i_a2_sh,
    input  logic [1:0]         i_fb_en,
    output logic               o_valid,
    output logic [NB_CH-1:0]   o_ch,
    output logic [NB_DATA-1:0] o_data
);

    // Six operands of at most 2^(NB_DATA-1) magnitude fit in NB_DATA+3 bits.
    localparam int unsigned ACC_W = NB_DATA + 3;
    localparam int unsigned EXT_W = ACC_W - NB_DATA;

    localparam logic [NB_CH:0] N_CH_W = (NB_CH + 1)'(N_CH);

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(EXT_W + 1){1'b0}}, {(NB_DATA - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(EXT_W + 1){1'b1}}, {(NB_DATA - 1){1'b0}}};

    // Per-channel history
    logic signed [NB_DATA-1:0] x1_q [N_CH];
    logic signed [NB_DATA-1:0] x2_q [N_CH];
    logic signed [NB_DATA-1:0] x3_q [N_CH];
    logic signed [NB_DATA-1:0] y1_q [N_CH];
    logic signed [NB_DATA-1:0] y2_q [N_CH];

    logic                      ch_ok;
    logic                      accept;
    logic [NB_CH-1:0]          ch_idx;
    logic signed [NB_DATA-1:0] x1_h, x2_h, x3_h, y1_h, y2_h;
    logic signed [NB_DATA-1:0] y1_sh, y2_sh;
    logic signed [ACC_W-1:0]   xs [4];
    logic signed [ACC_W-1:0]   acc;
    logic [NB_DATA-1:0]        res;

    assign ch_ok  = ({1'b0, i_ch} < N_CH_W);
    assign accept = i_valid && ch_ok;
    // Keep the array read index in range even when the sample is being dropped.
    assign ch_idx = ch_ok ? i_ch : '0;

    // Selected channel history, forced to zero when it is being cleared this cycle.
    always_comb begin
        x1_h = '0;
        x2_h = '0;
        x3_h = '0;
        y1_h = '0;
        y2_h = '0;
        if (!i_clr) begin
            x1_h = x1_q[ch_idx];
            x2_h = x2_q[ch_idx];
            x3_h = x3_q[ch_idx];
            y1_h = y1_q[ch_idx];
            y2_h = y2_q[ch_idx];
        end
    end

    assign y1_sh = y1_h >>> i_a1_sh;
    assign y2_sh = y2_h >>> i_a2_sh;

    always_comb begin
        xs[0] = {{EXT_W{i_data[NB_DATA-1]}}, i_data};
        xs[1] = {{EXT_W{x1_h[NB_DATA-1]}}, x1_h};
        xs[2] = {{EXT_W{x2_h[NB_DATA-1]}}, x2_h};
        xs[3] = {{EXT_W{x3_h[NB_DATA-1]}}, x3_h};
        acc   = '0;
        for (int k = 0; k < 4; k++) begin
            acc = i_b_neg[k] ? (acc - xs[k]) : (acc + xs[k]);
        end
        if (i_fb_en[0]) acc = acc + {{EXT_W{y1_sh[NB_DATA-1]}}, y1_sh};
        if (i_fb_en[1]) acc = acc + {{EXT_W{y2_sh[NB_DATA-1]}}, y2_sh};
    end

    always_comb begin
        res = acc[NB_DATA-1:0];
        if (SAT) begin
            if (acc > SAT_MAX) begin
                res = SAT_MAX[NB_DATA-1:0];
            end else if (acc < SAT_MIN) begin
                res = SAT_MIN[NB_DATA-1:0];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_ch    <= '0;
            o_data  <= '0;
            for (int c = 0; c < N_CH; c++) begin
                x1_q[c] <= '0;
                x2_q[c] <= '0;
                x3_q[c] <= '0;
                y1_q[c] <= '0;
                y2_q[c] <= '0;
            end
        end else begin
            o_valid <= accept;
            if (accept) begin
                o_ch   <= i_ch;
                o_data <= res;
            end
            for (int c = 0; c < N_CH; c++) begin
                if (ch_ok && (i_ch == NB_CH'(c))) begin
                    if (i_valid) begin
                        // Shift from the (possibly cleared) view used for this result.
                        x3_q[c] <= x2_h;
                        x2_q[c] <= x1_h;
                        x1_q[c] <= i_data;
                        y2_q[c] <= y1_h;
                        y1_q[c] <= res;
                    end else if (i_clr) begin
                        x1_q[c] <= '0;
                        x2_q[c] <= '0;
                        x3_q[c] <= '0;
                        y1_q[c] <= '0;
                        y2_q[c] <= '0;
                    end
                end
            end
        end
    end

endmodule
